// File: rtl/descriptor_writeback.sv
// Commits a 3-word descriptor to word-addressed RAM as consecutive writes at
// base, base+STEP, base+2*STEP, with RAM-side stall and a one-cycle done pulse.
module descriptor_writeback #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_STEP  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [3*WORD_WIDTH-1:0] descriptor,
  input  logic                    ram_ready,
  output logic                    ram_write_enable,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [WORD_WIDTH-1:0]   ram_data,
  output logic                    write_busy,
  output logic                    write_done
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_FST  = 5'b00010,
    S_SND  = 5'b00100,
    S_TRD  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [3*WORD_WIDTH-1:0] r_desc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_desc  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_base <= address;
        r_desc <= descriptor;
      end
    end
  end

  // Any non-one-hot encoding falls through to IDLE.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = start ? S_FST : S_IDLE;
      S_FST:  w_next = ram_ready ? S_SND : S_FST;
      S_SND:  w_next = ram_ready ? S_TRD : S_SND;
      S_TRD:  w_next = ram_ready ? S_DONE : S_TRD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decode only from registered state, so a stall holds them stable.
  always_comb begin
    ram_write_enable = 1'b0;
    ram_address      = '0;
    ram_data         = '0;
    write_busy       = 1'b0;
    write_done       = 1'b0;
    case (r_state)
      S_FST: begin
        ram_write_enable = 1'b1;
        ram_address      = r_base;
        ram_data         = r_desc[WORD_WIDTH-1:0];
        write_busy       = 1'b1;
      end
      S_SND: begin
        ram_write_enable = 1'b1;
        ram_address      = r_base + ADDR_WIDTH'(ADDR_STEP);
        ram_data         = r_desc[2*WORD_WIDTH-1:WORD_WIDTH];
        write_busy       = 1'b1;
      end
      S_TRD: begin
        ram_write_enable = 1'b1;
        ram_address      = r_base + ADDR_WIDTH'(2 * ADDR_STEP);
        ram_data         = r_desc[3*WORD_WIDTH-1:2*WORD_WIDTH];
        write_busy       = 1'b1;
      end
      S_DONE: begin
        write_busy = 1'b1;
        write_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_descriptor_writeback.sv
// Scoreboarded bench for descriptor_writeback: expected writes and done cycles
// are queued when stimulus is driven and consumed by a negedge monitor.
module tb_descriptor_writeback;

  logic        clk = 1'b0;
  logic        reset, start, ram_ready;
  logic [63:0] address;
  logic [95:0] descriptor;
  logic        ram_write_enable, write_busy, write_done;
  logic [63:0] ram_address;
  logic [31:0] ram_data;

  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  wr_t mon_e;
  int  mon_c;

  descriptor_writeback #(.ADDR_WIDTH(64), .WORD_WIDTH(32), .ADDR_STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .address(address),
    .descriptor(descriptor), .ram_ready(ram_ready),
    .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_data(ram_data), .write_busy(write_busy), .write_done(write_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted write and every done pulse must match the queues.
  always @(negedge clk) begin
    if (ram_write_enable === 1'b1 && ram_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%h data=%h required none", ram_address, ram_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ram_address, ram_data} !== {mon_e.a, mon_e.d}) begin
          failures++;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   ram_address, ram_data, mon_e.a, mon_e.d);
        end
      end
    end
    if (write_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got cycle=%0d required none", cyc);
      end else begin
        mon_c = done_q.pop_front();
        if (cyc !== mon_c) begin
          failures++;
          $display("FAIL done_cycle got %0d required %0d", cyc, mon_c);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input logic [63:0] a, input logic [95:0] d);
    exp_q.push_back('{a: a,        d: d[31:0]});
    exp_q.push_back('{a: a + 64'd4, d: d[63:32]});
    exp_q.push_back('{a: a + 64'd8, d: d[95:64]});
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ram_ready = 1'b1;
    address = '0; descriptor = '0;
    repeat (3) step();
    reset = 1'b0;
    checks++;
    if (ram_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got %b required 0", ram_write_enable); end
    checks++;
    if (ram_address !== 64'd0) begin failures++; $display("FAIL reset_addr got %h required 0", ram_address); end
    checks++;
    if (ram_data !== 32'd0) begin failures++; $display("FAIL reset_data got %h required 0", ram_data); end
    checks++;
    if (write_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", write_busy); end
    checks++;
    if (write_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b required 0", write_done); end
  endtask

  task automatic test_basic();
    int c;
    int busy_cnt;
    step();
    c = cyc; busy_cnt = 0;
    start = 1'b1; ram_ready = 1'b1;
    address = 64'h1000;
    descriptor = 96'hCCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    push_desc(64'h1000, 96'hCCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    done_q.push_back(c + 4);
    for (int i = 1; i <= 6; i++) begin
      step();
      start = 1'b0;
      if (write_busy === 1'b1) busy_cnt++;
      if (i == 1) begin
        checks++;
        if (ram_write_enable !== 1'b1) begin failures++; $display("FAIL basic_first_we got %b required 1", ram_write_enable); end
      end
    end
    checks++;
    if (busy_cnt !== 4) begin failures++; $display("FAIL basic_busy_cycles got %0d required 4", busy_cnt); end
  endtask

  task automatic test_stall();
    int c;
    step();
    c = cyc;
    start = 1'b1; ram_ready = 1'b1;
    address = 64'h1000;
    descriptor = 96'hCCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    push_desc(64'h1000, 96'hCCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    done_q.push_back(c + 6);
    for (int i = 1; i <= 8; i++) begin
      step();
      start = 1'b0;
      ram_ready = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      if (i >= 2 && i <= 4) begin
        checks++;
        if ({ram_write_enable, ram_address, ram_data} !== {1'b1, 64'h1004, 32'hBBBB_BBBB}) begin
          failures++;
          $display("FAIL stall_hold cyc+%0d got we=%b addr=%h data=%h required we=1 addr=1004 data=bbbbbbbb",
                   i, ram_write_enable, ram_address, ram_data);
        end
      end
    end
  endtask

  task automatic test_start_held();
    int c;
    logic [63:0] a2;
    logic [95:0] d2;
    a2 = 64'h0000_0000_2000_0040;
    d2 = {$urandom, $urandom, $urandom};
    step();
    c = cyc;
    start = 1'b1; ram_ready = 1'b1;
    address = 64'h3000;
    descriptor = 96'h3333_3333_2222_2222_1111_1111;
    push_desc(64'h3000, 96'h3333_3333_2222_2222_1111_1111);
    done_q.push_back(c + 4);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i <= 3) begin
        address = {$urandom, $urandom};
        descriptor = {$urandom, $urandom, $urandom};
      end else if (i == 4) begin
        address = a2;
        descriptor = d2;
        push_desc(a2, d2);
        done_q.push_back(c + 9);
      end else if (i == 5) begin
        checks++;
        if ({ram_write_enable, write_busy} !== 2'b00) begin
          failures++;
          $display("FAIL held_idle_gap got we=%b busy=%b required 0 0", ram_write_enable, write_busy);
        end
      end else if (i == 6) begin
        start = 1'b0;
        checks++;
        if ({ram_write_enable, ram_address} !== {1'b1, a2}) begin
          failures++;
          $display("FAIL held_second_accept got we=%b addr=%h required we=1 addr=%h", ram_write_enable, ram_address, a2);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [95:0] d;
    d = {$urandom, $urandom, $urandom};
    step();
    start = 1'b1; ram_ready = 1'b1;
    address = 64'hFFFF_FFFF_FFFF_FFFC;
    descriptor = d;
    exp_q.push_back('{a: 64'hFFFF_FFFF_FFFF_FFFC, d: d[31:0]});
    exp_q.push_back('{a: 64'h0,                   d: d[63:32]});
    exp_q.push_back('{a: 64'h4,                   d: d[95:64]});
    done_q.push_back(cyc + 4);
    for (int i = 1; i <= 6; i++) begin
      step();
      start = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    int c;
    step();
    c = cyc;
    start = 1'b1; ram_ready = 1'b1;
    address = 64'h5000;
    descriptor = 96'h9999_9999_8888_8888_7777_7777;
    exp_q.push_back('{a: 64'h5000, d: 32'h7777_7777});
    exp_q.push_back('{a: 64'h5004, d: 32'h8888_8888});
    for (int i = 1; i <= 8; i++) begin
      step();
      start = 1'b0;
      if (i == 3) begin
        checks++;
        if ({ram_write_enable, ram_address} !== {1'b1, 64'h5008}) begin
          failures++;
          $display("FAIL abort_in_trd got we=%b addr=%h required we=1 addr=5008", ram_write_enable, ram_address);
        end
        ram_ready = 1'b0;
        reset = 1'b1;
      end else if (i == 4) begin
        reset = 1'b0;
        ram_ready = 1'b1;
        checks++;
        if ({ram_write_enable, ram_address, ram_data, write_busy, write_done} !== '0) begin
          failures++;
          $display("FAIL abort_outputs got we=%b addr=%h data=%h busy=%b done=%b required all 0",
                   ram_write_enable, ram_address, ram_data, write_busy, write_done);
        end
      end
    end
    test_basic();
  endtask

  task automatic test_reset_with_start();
    step();
    reset = 1'b1; start = 1'b1; ram_ready = 1'b1;
    address = 64'h7000;
    descriptor = 96'h1;
    step();
    reset = 1'b0; start = 1'b0;
    checks++;
    if ({ram_write_enable, write_busy} !== 2'b00) begin
      failures++;
      $display("FAIL rst_start_edge got we=%b busy=%b required 0 0", ram_write_enable, write_busy);
    end
    step();
    checks++;
    if ({ram_write_enable, write_busy} !== 2'b00) begin
      failures++;
      $display("FAIL rst_start_after got we=%b busy=%b required 0 0", ram_write_enable, write_busy);
    end
  endtask

  task automatic test_drain();
    repeat (3) step();
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL missing_writes got %0d pending required 0", exp_q.size()); end
    checks++;
    if (done_q.size() !== 0) begin failures++; $display("FAIL missing_done got %0d pending required 0", done_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_held();
    test_wrap();
    test_reset_abort();
    test_reset_with_start();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/descriptor_writeback.md
# descriptor_writeback

Writes a 96-bit descriptor back to word-addressed system RAM as three consecutive 32-bit writes at base, base+4, base+8. It is the write-side counterpart of the descriptor fetch stage: the DMA/host controller engine uses it to commit updated descriptors (status, length, next pointer) to memory. A RAM-side ready handshake lets RAM stall the block, and a done pulse tells the controller when the descriptor is committed.

## Interface

- ADDR_WIDTH, 64, width of base and RAM addresses
- WORD_WIDTH, 32, width of one RAM write word; descriptor is 3*WORD_WIDTH
- ADDR_STEP, 4, byte increment between consecutive words

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- address  in  ADDR_WIDTH  descriptor base address, captured with start
- descriptor  in  3*WORD_WIDTH  descriptor to write, captured with start; [31:0] is word 0
- ram_ready  in  1  RAM accepts the current write in any cycle where ram_write_enable and ram_ready are both 1
- ram_write_enable  out  1  write request valid
- ram_address  out  ADDR_WIDTH  write address
- ram_data  out  WORD_WIDTH  write data
- write_busy  out  1  high from the cycle after start acceptance through DONE
- write_done  out  1  one-cycle pulse; descriptor fully committed

## Operation

- States: IDLE, FST_WRITE, SND_WRITE, TRD_WRITE, DONE. One-hot encoding. Illegal encodings go to IDLE on the next edge.
- IDLE: start=1 latches address into base_q and descriptor into desc_q, then moves to FST_WRITE. start=0 holds IDLE.
- FST_WRITE: drives ram_write_enable=1, ram_address=base_q, ram_data=desc_q[31:0].
- SND_WRITE: drives ram_write_enable=1, ram_address=base_q+ADDR_STEP, ram_data=desc_q[63:32].
- TRD_WRITE: drives ram_write_enable=1, ram_address=base_q+2*ADDR_STEP, ram_data=desc_q[95:64].
- Each WRITE state advances only when ram_ready=1. With ram_ready=0, the state and all outputs hold unchanged, and address and data stay stable.
- TRD_WRITE accepted: moves to DONE. DONE drives write_done=1 and write_busy=1 with no write, then returns to IDLE unconditionally.
- start outside IDLE, including DONE, is ignored and not queued. address and descriptor changes after capture have no effect.
- Address arithmetic is modulo 2^ADDR_WIDTH. A base near the maximum wraps silently, e.g. base 0xFFFF_FFFF_FFFF_FFFC gives words at ...FFFC, 0x0, 0x4.
- In IDLE and DONE: ram_write_enable=0, ram_address=0, ram_data=0.
- Reset in any state, including mid-write with a stalled RAM, goes to IDLE on that edge. No further writes are issued. Partially written words are not rolled back.
- Reset dominates a start asserted in the same cycle.

## Timing

- Reset values: state=IDLE, ram_write_enable=0, ram_address=0, ram_data=0, write_busy=0, write_done=0, base_q=0, desc_q=0.
- All outputs decode from registered state and registers; there is no combinational path from any input to any output.
- start sampled high at edge N: FST_WRITE is visible in cycle N+1.
- With ram_ready held at 1: writes occur in cycles N+1, N+2, N+3, write_done=1 in cycle N+4, and the next start is accepted at the end of cycle N+5 (IDLE).
- Minimum start-to-done latency is 4 cycles. Each stalled cycle (ram_ready=0 during a WRITE state) adds exactly 1 cycle.
- Back-to-back throughput is one descriptor per 5 cycles.
- write_done is high for exactly one cycle per accepted start, and never after a reset abort.

## Test plan

- Reset, then start with address=0x1000 and descriptor=0xCCCC_CCCC_BBBB_BBBB_AAAA_AAAA, ram_ready=1 -> writes (0x1000, 0xAAAAAAAA), (0x1004, 0xBBBBBBBB), (0x1008, 0xCCCCCCCC) in 3 consecutive cycles; write_done pulses at start+4; write_busy=1 for 4 cycles.
- Same stimulus with ram_ready=0 for 2 cycles during SND_WRITE -> address 0x1004 and data 0xBBBBBBBB held stable for 3 cycles; write_done at start+6; no duplicate or skipped writes.
- start held high continuously, and inputs changed mid-transfer -> the first descriptor is written with its captured values; the second is accepted only from IDLE, 5 cycles after the first acceptance.
- Base 0xFFFF_FFFF_FFFF_FFFC -> write addresses 0xFFFF_FFFF_FFFF_FFFC, 0x0, 0x4.
- Reset asserted during TRD_WRITE with ram_ready=0 -> next cycle all outputs are 0, write_done never pulses, and a fresh start afterwards completes normally.
- Reset and start asserted together -> block stays IDLE with no write.
